logic_op_arbiter: RTL and testbench
===================================

LOGIC_OP_ARBITER -- requirements
Module: logic_op_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port req_valid, input, 4 bits: bit i set means requester i presents an operation.
REQ-005 The block SHALL have port req_ready, output, 4 bits: bit i set means requester i's operation is accepted this cycle.
REQ-006 The block SHALL have port req_op, input, 12 bits: opcode of requester i in bits [3i+2:3i].
REQ-007 The block SHALL have port req_a, input, 4*WIDTH bits: operand A of requester i in slice i.
REQ-008 The block SHALL have port req_b, input, 4*WIDTH bits: operand B of requester i in slice i.
REQ-009 The block SHALL have port rsp_valid, output, 1 bit: a result is held on the rsp_* outputs.
REQ-010 The block SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result this cycle.
REQ-011 The block SHALL have port rsp_id, output, 2 bits: index of the requester that owns the result.
REQ-012 The block SHALL have port rsp_data, output, WIDTH bits: the bitwise result.
REQ-013 The block SHALL have port rsp_err, output, 1 bit: the opcode was illegal.

Function
REQ-014 Opcodes SHALL decode as follows, applied bitwise over WIDTH bits:
- 0 AND
- 1 OR
- 2 NAND
- 3 NOR
- 4 XOR
- 5 XNOR
REQ-015 Opcodes 6 and 7 SHALL produce rsp_data all-zero and rsp_err=1; legal opcodes SHALL produce rsp_err=0.
REQ-016 The block SHALL implement a two-state output FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 The slot SHALL be free in a cycle when the state is EMPTY, or when the state is FULL and rsp_ready=1.
REQ-018 When the slot is free and any req_valid bit is set, the block SHALL assert exactly one req_ready bit, chosen round-robin (combinational from req_valid, state, rsp_ready and the pointer).
REQ-019 When the slot is not free, or when req_valid is zero, req_ready SHALL be all-zero.
REQ-020 A req_ready bit SHALL never be asserted for a requester whose req_valid is 0.
REQ-021 Round-robin search SHALL start at pointer ptr (2 bits) and proceed ptr, ptr+1, ... modulo 4.
REQ-022 After a grant to requester g, ptr SHALL become (g+1) mod 4; without a grant, ptr SHALL be unchanged.
REQ-023 On a grant, the result, the id g and the error flag SHALL be registered at the next rising edge, with rsp_valid=1 in the following cycle (latency 1 cycle).
REQ-024 FSM transitions:
- EMPTY->FULL on grant.
- FULL->EMPTY on rsp_ready=1 with no grant.
- FULL->FULL with new contents on rsp_ready=1 with a grant (back-to-back, full throughput).
- FULL->FULL holding contents on rsp_ready=0.
REQ-025 While FULL and rsp_ready=0, rsp_id, rsp_data and rsp_err SHALL remain stable.
REQ-026 A requester SHALL hold req_valid and its payload until it sees req_ready; a requester that drops req_valid before its grant SHALL simply not be granted (no error).
REQ-027 The block SHALL sample operands only in the grant cycle; operand changes after the grant SHALL NOT affect the registered result.
REQ-028 In EMPTY, rsp_ready SHALL be ignored.

Reset
REQ-029 With rst_n=0 at a rising edge, the next-cycle values SHALL be: state EMPTY, rsp_valid=0, ptr=0, rsp_id=0, rsp_data=0, rsp_err=0.
REQ-030 req_ready SHALL be all-zero in any cycle with rst_n=0, regardless of req_valid.
REQ-031 Reset asserted while FULL SHALL discard the held result; no response for it SHALL appear after reset.

Verification
REQ-032 Single op: WIDTH=8, reset released, req_valid=0001, op=4, a=8'hF0, b=8'h3C, rsp_ready=1 -> req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=8'hCC, rsp_err=0.
REQ-033 Fairness: req_valid=1111 held with rsp_ready=1 from ptr=0 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle, rsp_id following 0,1,2,3,0.
REQ-034 Stall: FULL with rsp_ready=0 for 3 cycles while req_valid=0010 -> req_ready=0000 and rsp_* stable; cycle rsp_ready=1 -> req_ready=0010, next cycle rsp_id=1.
REQ-035 Illegal op: op=7, a=8'hFF, b=8'hFF -> rsp_data=8'h00, rsp_err=1; then op=2 (NAND), a=8'hFF, b=8'h0F -> rsp_data=8'hF0, rsp_err=0.
REQ-036 Reset mid-op: rst_n=0 while FULL with rsp_ready=0 -> next cycle rsp_valid=0, ptr=0; with req_valid=1000 after release -> grant to 3, then ptr=0.
REQ-037 All opcodes: a=8'hA5, b=8'h0F through ops 0..5 -> rsp_data 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// Four-requester round-robin arbiter. It computes a bitwise logic operation
// for the granted requester and holds the result in a single output slot.
module logic_op_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         req_valid,
  output logic [3:0]         req_ready,
  input  logic [11:0]        req_op,
  input  logic [4*WIDTH-1:0] req_a,
  input  logic [4*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_err
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic             slot_free;
  logic             gnt_any;
  logic [1:0]       gnt_idx;
  logic [1:0]       idx;
  logic [2:0]       gnt_op;
  logic [WIDTH-1:0] gnt_a;
  logic [WIDTH-1:0] gnt_b;
  logic [WIDTH-1:0] result;
  logic             illegal;

  assign slot_free = (state == EMPTY) || rsp_ready;

  // Search begins at ptr and wraps; no grant while in reset or while the slot is busy.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = 2'd0;
    idx     = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
    if (!rst_n || !slot_free) begin
      gnt_any = 1'b0;
    end
  end

  always_comb begin
    req_ready = 4'b0000;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_op = req_op[3*gnt_idx +: 3];
  assign gnt_a  = req_a[WIDTH*gnt_idx +: WIDTH];
  assign gnt_b  = req_b[WIDTH*gnt_idx +: WIDTH];

  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (gnt_op)
      3'd0:    result = gnt_a & gnt_b;
      3'd1:    result = gnt_a | gnt_b;
      3'd2:    result = ~(gnt_a & gnt_b);
      3'd3:    result = ~(gnt_a | gnt_b);
      3'd4:    result = gnt_a ^ gnt_b;
      3'd5:    result = ~(gnt_a ^ gnt_b);
      default: illegal = 1'b1;
    endcase
  end

  // A grant always reloads the slot, so back-to-back traffic never bubbles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= 2'd0;
      rsp_id   <= 2'd0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else if (gnt_any) begin
      state    <= FULL;
      ptr      <= gnt_idx + 2'd1;
      rsp_id   <= gnt_idx;
      rsp_data <= result;
      rsp_err  <= illegal;
    end else if (state == FULL && rsp_ready) begin
      state <= EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_logic_op_arbiter;

  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [11:0]        req_op;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [1:0]         rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_err;

  int total_checks = 0;
  int bad_checks   = 0;

  // Reference model: one response slot plus the rotating search start.
  bit         exp_valid;
  int         exp_id;
  logic [7:0] exp_data;
  bit         exp_err;
  int         exp_ptr;

  logic [7:0] op_table [6];

  always #5 clk = ~clk;

  logic_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  function automatic logic [8:0] ref_result(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0:       return {1'b0, a & b};
      1:       return {1'b0, a | b};
      2:       return {1'b0, ~(a & b)};
      3:       return {1'b0, ~(a | b)};
      4:       return {1'b0, a ^ b};
      5:       return {1'b0, ~(a ^ b)};
      default: return {1'b1, 8'h00};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock cycle: check held outputs, drive inputs, check grant, advance model.
  task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic [11:0] op,
                               input logic [31:0] a, input logic [31:0] b, input logic rdy);
    int         g;
    bit         free;
    logic [3:0] exp_ready;
    logic [8:0] res;
    @(negedge clk);
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("rsp_id", 32'(rsp_id), 32'(exp_id));
      checkOutput("rsp_data", 32'(rsp_data), 32'(exp_data));
      checkOutput("rsp_err", 32'(rsp_err), 32'(exp_err));
    end
    rst_n     = rst;
    req_valid = valid;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = rdy;
    #1;
    g    = -1;
    free = !exp_valid || rdy;
    if (rst && free) begin
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && valid[(exp_ptr + k) % 4]) g = (exp_ptr + k) % 4;
      end
    end
    exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    @(posedge clk);
    if (!rst) begin
      exp_valid = 0;
      exp_ptr   = 0;
      exp_id    = 0;
      exp_data  = 8'h00;
      exp_err   = 0;
    end else if (g >= 0) begin
      res       = ref_result(int'(op[3*g +: 3]), a[8*g +: 8], b[8*g +: 8]);
      exp_valid = 1;
      exp_id    = g;
      exp_data  = res[7:0];
      exp_err   = res[8];
      exp_ptr   = (g + 1) % 4;
    end else if (exp_valid && rdy) begin
      exp_valid = 0;
    end
  endtask

  initial begin
    op_table = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55};
    exp_valid = 0; exp_id = 0; exp_data = 8'h00; exp_err = 0; exp_ptr = 0;
    rst_n = 1'b0; req_valid = 4'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;

    // Reset state, including reset held with requests pending.
    applyStimulus(1'b0, 4'b1111, '0, '0, '0, 1'b1);
    applyStimulus(1'b0, 4'b0000, '0, '0, '0, 1'b0);
    #1;
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_data", 32'(rsp_data), 32'd0);
    checkOutput("reset_id", 32'(rsp_id), 32'd0);
    checkOutput("reset_err", 32'(rsp_err), 32'd0);

    // Single XOR operation.
    applyStimulus(1'b1, 4'b0001, {4{3'd4}}, {4{8'hF0}}, {4{8'h3C}}, 1'b1);
    #1;
    checkOutput("single_valid", 32'(rsp_valid), 32'd1);
    checkOutput("single_data", 32'(rsp_data), 32'hCC);
    checkOutput("single_id", 32'(rsp_id), 32'd0);

    // Fairness from ptr=0 with all requesters active.
    applyStimulus(1'b0, 4'b0000, '0, '0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 4'b1111, {4{3'd1}}, 32'h44332211, 32'h00000000, 1'b1);
      #1;
      checkOutput("fair_id", 32'(rsp_id), 32'(i % 4));
    end

    // Stall for three cycles, then release.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'b0010, {4{3'd0}}, '1, '1, 1'b0);
    applyStimulus(1'b1, 4'b0010, {4{3'd0}}, '1, '1, 1'b1);
    #1;
    checkOutput("stall_id", 32'(rsp_id), 32'd1);

    // Illegal opcode, then NAND.
    applyStimulus(1'b1, 4'b0001, {4{3'd7}}, {4{8'hFF}}, {4{8'hFF}}, 1'b1);
    #1;
    checkOutput("illegal_data", 32'(rsp_data), 32'h00);
    checkOutput("illegal_err", 32'(rsp_err), 32'd1);
    applyStimulus(1'b1, 4'b0001, {4{3'd2}}, {4{8'hFF}}, {4{8'h0F}}, 1'b1);
    #1;
    checkOutput("nand_data", 32'(rsp_data), 32'hF0);
    checkOutput("nand_err", 32'(rsp_err), 32'd0);

    // Reset while FULL and stalled discards the held result.
    applyStimulus(1'b0, 4'b0000, '0, '0, '0, 1'b0);
    #1;
    checkOutput("midreset_valid", 32'(rsp_valid), 32'd0);
    applyStimulus(1'b1, 4'b1000, {4{3'd1}}, '0, '0, 1'b0);
    #1;
    checkOutput("midreset_id", 32'(rsp_id), 32'd3);
    applyStimulus(1'b1, 4'b1111, {4{3'd1}}, '0, '0, 1'b1);
    #1;
    checkOutput("ptr_wrap_id", 32'(rsp_id), 32'd0);

    // Every legal opcode on a fixed operand pair.
    for (int op = 0; op < 6; op++) begin
      applyStimulus(1'b1, 4'b0001, {4{3'(op)}}, {4{8'hA5}}, {4{8'h0F}}, 1'b1);
      #1;
      checkOutput("opcode_data", 32'(rsp_data), 32'(op_table[op]));
    end

    // Randomized traffic, with occasional resets and consumer back-pressure.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), 4'($urandom), 12'($urandom),
                    $urandom, $urandom, ($urandom_range(0, 9) < 7));
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
